// File: rtl/div_pkg.sv
// Shared types and constants for the restoring unsigned divider.
package div_pkg;

  // Default operand width; outputs are DIV_N/2 bits wide.
  localparam int unsigned DIV_N = 48;

  // Iteration counter width for a given operand width.
  function automatic int unsigned div_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DIV_CW = div_cnt_width(DIV_N);

  typedef enum logic {LOAD, ITER} div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic [N:0]   r,
  input  logic         d_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N+1:0] t;

  // The partial remainder is always below the divisor, so r[N] is zero and the
  // wide shift equals {r[N-1:0], d_msb}; keeping it wide costs nothing.
  always_comb begin
    t = {r, d_msb};
    if (t >= {2'b00, divisor}) begin
      r_next = t[N:0] - {1'b0, divisor};
      q_bit  = 1'b1;
    end else begin
      r_next = t[N:0];
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/unsigned_div.sv
// Free-running restoring unsigned divider: LOAD for one cycle, then N ITER cycles,
// publishing the low halves of quotient and remainder on the last ITER edge.
// Optional macro DIV_ZERO_HOLD_EN: a zero divisor leaves the outputs unchanged.
// N must be even and at least 4.
module unsigned_div
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  output logic [N/2-1:0] Quotient,
  output logic [N/2-1:0] Remainder
);

  localparam int unsigned CW = div_cnt_width(N);
  localparam int unsigned H  = N / 2;

  div_state_t  state_q;
  logic [CW-1:0] count_q;
  logic [N-1:0]  divisor_q;
  logic [N-1:0]  d_q;
  logic [N:0]    r_q;

  logic [N:0]    r_next;
  logic          q_bit;
  logic          publish;

  div_step #(
    .N (N)
  ) u_step (
    .r       (r_q),
    .d_msb   (d_q[N-1]),
    .divisor (divisor_q),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

`ifdef DIV_ZERO_HOLD_EN
  // A zero divisor would yield a meaningless result; keep the previous one.
  assign publish = (divisor_q != '0);
`else
  assign publish = 1'b1;
`endif

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= LOAD;
      count_q   <= '0;
      divisor_q <= '0;
      d_q       <= '0;
      r_q       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          divisor_q <= M;
          d_q       <= Q;
          r_q       <= '0;
          count_q   <= '0;
          state_q   <= ITER;
        end
        ITER: begin
          r_q     <= r_next;
          d_q     <= {d_q[N-2:0], q_bit};
          count_q <= count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            if (publish) begin
              Quotient  <= {d_q[H-2:0], q_bit};
              Remainder <= r_next[H-1:0];
            end
            state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_div.sv
// Self-checking bench for unsigned_div (N=48) against an arithmetic reference model.
module tb_unsigned_div;

  localparam int N = 48;
  localparam int H = N / 2;

  logic         clk;
  logic         rstn;
  logic [N-1:0] M;
  logic [N-1:0] Q;
  logic [H-1:0] Quotient;
  logic [H-1:0] Remainder;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected values of the most recently published result.
  logic [H-1:0] exp_q = '0;
  logic [H-1:0] exp_r = '0;

  unsigned_div #(
    .N (N)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .M         (M),
    .Q         (Q),
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncated to the output width.
  task automatic model(input logic [N-1:0] m, input logic [N-1:0] q,
                       output logic [H-1:0] eq, output logic [H-1:0] er);
    if (m == '0) begin
`ifdef DIV_ZERO_HOLD_EN
      eq = exp_q;
      er = exp_r;
`else
      eq = '1;
      er = q[H-1:0];
`endif
    end else begin
      logic [N-1:0] fq;
      logic [N-1:0] fr;
      fq = q / m;
      fr = q % m;
      eq = fq[H-1:0];
      er = fr[H-1:0];
    end
  endtask

  // Called with the next rising edge being a LOAD edge. Optionally changes M
  // after edge mid_edge (counting the LOAD edge as 1), which must not matter.
  task automatic run_op(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                        input int mid_edge, input logic [N-1:0] m_mid);
    logic [H-1:0] nq;
    logic [H-1:0] nr;
    M = m;
    Q = q;
    model(m, q, nq, nr);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      if (i == mid_edge) begin
        #1;
        M = m_mid;
      end
    end
    #1;
    check({tag, "_hold_q"}, {40'd0, Quotient}, {40'd0, exp_q});
    check({tag, "_hold_r"}, {40'd0, Remainder}, {40'd0, exp_r});
    @(posedge clk);
    #1;
    check({tag, "_q"}, {40'd0, Quotient}, {40'd0, nq});
    check({tag, "_r"}, {40'd0, Remainder}, {40'd0, nr});
    exp_q = nq;
    exp_r = nr;
  endtask

  initial begin
    logic [63:0]  big_q;
    logic [N-1:0] rm;
    logic [N-1:0] rq;

    rstn = 1'b1;
    M    = 48'hABCD_1234_5678;
    Q    = 48'h0F0F_F0F0_1234;

    // Asynchronous clear with no clock edge yet.
    #1 rstn = 1'b0;
    #1;
    check("rst_async_q", {40'd0, Quotient}, 64'd0);
    check("rst_async_r", {40'd0, Remainder}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_q", {40'd0, Quotient}, 64'd0);
    check("rst_hold_r", {40'd0, Remainder}, 64'd0);

    @(negedge clk);
    rstn = 1'b1;

    // Small operands, repeated to confirm the period.
    run_op("small1", 48'd7, 48'd100, 0, '0);
    check("small_const_q", {40'd0, Quotient}, 64'd14);
    check("small_const_r", {40'd0, Remainder}, 64'd2);
    run_op("small2", 48'd7, 48'd100, 0, '0);

    // Divisor change mid-iteration only affects the following period.
    run_op("midchg1", 48'd7, 48'd100, 10, 48'd5);
    run_op("midchg2", 48'd5, 48'd100, 0, '0);
    check("midchg_const_q", {40'd0, Quotient}, 64'd20);
    check("midchg_const_r", {40'd0, Remainder}, 64'd0);

    // Large operands; the dividend literal is wider than the port, so the
    // port sees it modulo 2^48 exactly as the model does.
    big_q = 64'd356478892927895;
    run_op("large", 48'd2657890056, big_q[N-1:0], 0, '0);
    run_op("trunc", 48'd1, 48'hFFFF_FFFF_FFFF, 0, '0);
    run_op("m_gt_q", 48'hFFFF_FFFF_FFFF, 48'h0000_00AB_CDEF, 0, '0);
    run_op("m_eq_q", 48'h8000_0000_0001, 48'h8000_0000_0001, 0, '0);

    // Divide by zero.
    run_op("divzero", 48'd0, 48'h1234_5678_9ABC, 0, '0);
`ifndef DIV_ZERO_HOLD_EN
    check("divzero_const_q", {40'd0, Quotient}, 64'hFF_FFFF);
    check("divzero_const_r", {40'd0, Remainder}, 64'h78_9ABC);
`endif

    // Randomized operands of varying magnitude.
    for (int i = 0; i < 20; i++) begin
      rm = {$urandom, $urandom} >> $urandom_range(0, 47);
      rq = {$urandom, $urandom} >> $urandom_range(0, 20);
      run_op($sformatf("rand%0d", i), rm, rq, 0, '0);
    end

    // Make sure a nonzero result is on the outputs before the mid-ITER reset.
    run_op("pre_rst", 48'd7, 48'd100, 0, '0);
    M = 48'd3;
    Q = 48'd1000;
    repeat (20) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midrst_q", {40'd0, Quotient}, 64'd0);
    check("midrst_r", {40'd0, Remainder}, 64'd0);
    exp_q = '0;
    exp_r = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_op("post_rst", 48'd7, 48'd100, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
